// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs control-level fields into 32-bit words and streams them
// into instruction memory at consecutive word addresses, one cycle after each accept.
module instr_encoder #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [2:0]                    req_fmt_i,
    input  logic [6:0]                    req_opcode_i,
    input  logic [4:0]                    req_rd_i,
    input  logic [4:0]                    req_rs1_i,
    input  logic [4:0]                    req_rs2_i,
    input  logic [2:0]                    req_funct3_i,
    input  logic [6:0]                    req_funct7_i,
    input  logic [31:0]                   req_imm_i,
    input  logic                          clr_i,
    output logic                          imem_we_o,
    output logic [31:0]                   imem_addr_o,
    output logic [31:0]                   imem_wdata_o,
    output logic [$clog2(IMEM_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          err_fmt_o
);

    localparam int unsigned CntW = $clog2(IMEM_DEPTH) + 1;
    localparam logic [31:0] Nop  = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StEmit, StFull} state_e;

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic              full_q;
    logic              err_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              last_slot;
    logic              fmt_bad;
    logic [31:0]       word_d;
    logic [31:0]       addr_d;

    assign req_ready_o = ~full_q & ~clr_i;
    assign accept      = req_valid_i & req_ready_o;
    assign last_slot   = (count_q == CntW'(IMEM_DEPTH - 1));
    assign addr_d      = BASE_ADDR + (32'(count_q) << 2);

    always_comb begin
        word_d  = Nop;
        fmt_bad = 1'b0;
        case (req_fmt_i)
            3'b000: word_d = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i,
                              req_opcode_i};
            3'b001: word_d = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i,
                              req_opcode_i};
            3'b010: word_d = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                              req_imm_i[4:0], req_opcode_i};
            3'b011: word_d = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                              req_funct3_i, req_imm_i[4:1], req_imm_i[11], req_opcode_i};
            3'b100: word_d = {req_imm_i[31:12], req_rd_i, req_opcode_i};
            3'b101: word_d = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                              req_imm_i[19:12], req_rd_i, req_opcode_i};
            default: begin
                word_d  = Nop;
                fmt_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= accept;
            if (clr_i) begin
                // A write registered last cycle still goes out; only the pointer resets.
                state_q <= StIdle;
                count_q <= '0;
                full_q  <= 1'b0;
            end else if (accept) begin
                addr_q  <= addr_d;
                wdata_q <= word_d;
                count_q <= count_q + 1'b1;
                if (fmt_bad) begin
                    err_q <= 1'b1;
                end
                if (last_slot) begin
                    full_q  <= 1'b1;
                    state_q <= StFull;
                end else begin
                    state_q <= StEmit;
                end
            end else if (state_q == StEmit) begin
                state_q <= StIdle;
            end
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign err_fmt_o    = err_q;

endmodule
